// File: rtl/mt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mt_pkg
// Description : Shared MT19937 constants, untemper FSM state encoding and a
//               tempering helper used by the generator and its companions.
// Revision    : 1.0 - initial release
// ============================================================================
package mt_pkg;

    localparam int MT_N = 624;

    localparam logic [31:0] MT_TEMPER_B = 32'h9D2C5680;
    localparam logic [31:0] MT_TEMPER_C = 32'hEFC60000;

    localparam int MT_SHIFT_U = 11;
    localparam int MT_SHIFT_S = 7;
    localparam int MT_SHIFT_T = 15;
    localparam int MT_SHIFT_L = 18;

    typedef enum logic [3:0] {
        MT_ST_IDLE = 4'd0,
        MT_ST_U18  = 4'd1,
        MT_ST_U15  = 4'd2,
        MT_ST_U7   = 4'd3,
        MT_ST_U11  = 4'd4,
        MT_ST_WR   = 4'd5
    } mt_state_e;

    // Forward tempering of one state word, as applied by the generator.
    function automatic logic [31:0] mt_temper(input logic [31:0] y_in);
        logic [31:0] y;
        y = y_in;
        y = y ^ (y >> MT_SHIFT_U);
        y = y ^ ((y << MT_SHIFT_S) & MT_TEMPER_B);
        y = y ^ ((y << MT_SHIFT_T) & MT_TEMPER_C);
        y = y ^ (y >> MT_SHIFT_L);
        return y;
    endfunction

endpackage : mt_pkg
`default_nettype wire

// File: rtl/mt_state_ram.sv
`default_nettype none
// ============================================================================
// Module      : mt_state_ram
// Description : Single write port, registered read-first read port state RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module mt_state_ram #(
    parameter int DEPTH = 624,
    parameter int AW    = 10,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    (* ram_style = "block" *) logic [DW-1:0] r_mem [0:DEPTH-1];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Non-blocking read of the array gives read-first behaviour on a collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : mt_state_ram
`default_nettype wire

// File: rtl/mt_untemper.sv
`default_nettype none
// ============================================================================
// Module      : mt_untemper
// Description : Inverts MT19937 tempering word by word and captures N recovered
//               state words into a readable RAM. Optional re-temper checker is
//               enabled by defining MT_UNTEMPER_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mt_untemper
    import mt_pkg::*;
#(
    parameter int N = MT_N
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic [9:0]  count,
    output logic        state_ready,
    input  logic [9:0]  rd_addr,
    output logic [31:0] rd_data
`ifdef MT_UNTEMPER_CHECK_EN
    ,
    output logic        err
`endif
);

    localparam logic [3:0] S_IDLE = MT_ST_IDLE;
    localparam logic [3:0] S_U18  = MT_ST_U18;
    localparam logic [3:0] S_U15  = MT_ST_U15;
    localparam logic [3:0] S_U7   = MT_ST_U7;
    localparam logic [3:0] S_U11  = MT_ST_U11;
    localparam logic [3:0] S_WR   = MT_ST_WR;

    localparam logic [9:0] c_last_idx = 10'(N - 1);

    logic [3:0]  r_state;
    logic [31:0] r_y;
    logic [31:0] r_x;
    logic [1:0]  r_sub;
    logic [9:0]  r_count;
    logic        r_state_ready;

    logic        w_in_ready;
    logic        w_accept;
    logic        w_we;
    logic [31:0] w_u18;
    logic [31:0] w_u15;
    logic [31:0] w_u7;
    logic [31:0] w_u11;

    assign w_in_ready = (r_state == S_IDLE) && !r_state_ready;
    assign w_accept   = in_valid && w_in_ready && !start;
    assign w_we       = (r_state == S_WR) && !start;

    // Each step inverts one tempering stage, last stage first.
    assign w_u18 = r_y ^ (r_y >> MT_SHIFT_L);
    assign w_u15 = r_y ^ ((r_y << MT_SHIFT_T) & MT_TEMPER_C);
    assign w_u7  = r_x ^ ((r_y << MT_SHIFT_S) & MT_TEMPER_B);
    assign w_u11 = r_y ^ (r_y >> MT_SHIFT_U) ^ (r_y >> (2 * MT_SHIFT_U));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_y           <= '0;
            r_x           <= '0;
            r_sub         <= '0;
            r_count       <= '0;
            r_state_ready <= 1'b0;
        end else if (start) begin
            r_state       <= S_IDLE;
            r_count       <= '0;
            r_state_ready <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_y     <= in_data;
                        r_state <= S_U18;
                    end
                end
                S_U18: begin
                    r_y     <= w_u18;
                    r_state <= S_U15;
                end
                S_U15: begin
                    r_y     <= w_u15;
                    r_x     <= w_u15;
                    r_sub   <= '0;
                    r_state <= S_U7;
                end
                S_U7: begin
                    // Four passes recover 7 more correct low bits each.
                    r_y   <= w_u7;
                    r_sub <= r_sub + 2'd1;
                    if (r_sub == 2'd3) begin
                        r_state <= S_U11;
                    end
                end
                S_U11: begin
                    r_y     <= w_u11;
                    r_state <= S_WR;
                end
                S_WR: begin
                    r_count <= r_count + 10'd1;
                    if (r_count == c_last_idx) begin
                        r_state_ready <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef MT_UNTEMPER_CHECK_EN
    logic [31:0] r_orig;
    logic        r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_orig <= '0;
            r_err  <= 1'b0;
        end else if (start) begin
            r_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_orig <= in_data;
            end
            if (w_we && (mt_temper(r_y) != r_orig)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`endif

    mt_state_ram #(
        .DEPTH (N),
        .AW    (10),
        .DW    (32)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_waddr (r_count),
        .i_wdata (r_y),
        .i_raddr (rd_addr),
        .o_rdata (rd_data)
    );

    assign in_ready    = w_in_ready;
    assign count       = r_count;
    assign state_ready = r_state_ready;

endmodule : mt_untemper
`default_nettype wire

// File: tb/tb_mt_untemper.sv
`default_nettype none
// ============================================================================
// Module      : tb_mt_untemper
// Description : Self-checking bench for mt_untemper against an MT19937 model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mt_untemper;

    localparam int N = 624;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic [9:0]  count;
    logic        state_ready;
    logic [9:0]  rd_addr;
    logic [31:0] rd_data;
`ifdef MT_UNTEMPER_CHECK_EN
    logic        err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] gen_state [N];
    logic [31:0] d;
    bit          ok;

    always #5 clk = ~clk;

    mt_untemper #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .count       (count),
        .state_ready (state_ready),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
`ifdef MT_UNTEMPER_CHECK_EN
        ,
        .err         (err)
`endif
    );

    function automatic logic [31:0] temper(input logic [31:0] v);
        logic [31:0] y;
        y = v;
        y = y ^ (y >> 11);
        y = y ^ ((y << 7) & 32'h9D2C5680);
        y = y ^ ((y << 15) & 32'hEFC60000);
        y = y ^ (y >> 18);
        return y;
    endfunction

    // Seed and regenerate once: gen_state then holds the words whose tempered
    // forms are the generator's first N outputs.
    task automatic build_generator();
        logic [31:0] mt [N];
        logic [31:0] y;
        mt[0] = 32'd5489;
        for (int i = 1; i < N; i++) begin
            mt[i] = 32'd1812433253 * (mt[i-1] ^ (mt[i-1] >> 30)) + 32'(i);
        end
        for (int i = 0; i < N; i++) begin
            y = (mt[i] & 32'h80000000) | (mt[(i+1) % N] & 32'h7FFFFFFF);
            mt[i] = mt[(i+397) % N] ^ (y >> 1) ^ (y[0] ? 32'h9908B0DF : 32'h0);
        end
        for (int i = 0; i < N; i++) gen_state[i] = mt[i];
    endtask

    // Returns just after the accepting edge; ok=0 if in_ready never came.
    task automatic send_word(input logic [31:0] w, input int gap, output bit acc);
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = w;
        acc      = 1'b0;
        for (int t = 0; t < 100; t++) begin
            if (in_ready) begin
                acc = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_checks++;
        if (!acc) begin
            n_fail++;
            $display("FAIL accept_timeout: in_ready=%0b required 1 within 100 cycles", in_ready);
        end
    endtask

    task automatic rd(input int a, output logic [31:0] v);
        @(negedge clk);
        rd_addr = 10'(a);
        @(posedge clk);
        #1;
        v = rd_data;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; rd_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_state_ready", 32'(state_ready), 32'd0);
        chk("reset_rd_data", rd_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_word();
        send_word(32'h00400091, 0, ok);
        // Word occupies a 9-cycle slot; RAM write lands on the 8th edge after accept.
        repeat (7) @(posedge clk);
        #1;
        chk("latency_count_before", 32'(count), 32'd0);
        @(posedge clk);
        #1;
        chk("latency_count_after", 32'(count), 32'd1);
        rd(0, d);
        chk("single_ram0", d, 32'h00000001);
        send_word(32'h00000000, 0, ok);
        repeat (8) @(posedge clk);
        #1;
        chk("single_count2", 32'(count), 32'd2);
        rd(1, d);
        chk("single_ram1", d, 32'h00000000);
    endtask

    task automatic test_random_words();
        logic [31:0] s [6];
        for (int i = 0; i < 6; i++) begin
            s[i] = $urandom;
            send_word(temper(s[i]), int'($urandom_range(0, 3)), ok);
        end
        repeat (10) @(posedge clk);
        #1;
        chk("random_count", 32'(count), 32'd8);
        for (int i = 0; i < 6; i++) begin
            rd(2 + i, d);
            chk("random_ram", d, s[i]);
        end
    endtask

    task automatic test_abort();
        logic [31:0] s1, s2, s3;
        s1 = $urandom | 32'h100; s2 = $urandom; s3 = $urandom | 32'h200;
        pulse_start();
        chk("start_clears_count", 32'(count), 32'd0);
        send_word(temper(s1), 0, ok);
        repeat (3) @(posedge clk);
        @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = temper(s2);
        @(posedge clk);
        #1;
        chk("abort_count", 32'(count), 32'd0);
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("abort_no_write_count", 32'(count), 32'd0);
        rd(0, d);
        chk("abort_ram0_untouched", d, 32'h00000001);
        send_word(temper(s3), 0, ok);
        repeat (8) @(posedge clk);
        #1;
        chk("abort_next_count", 32'(count), 32'd1);
        rd(0, d);
        chk("abort_next_ram0", d, s3);
    endtask

    task automatic test_async_reset();
        pulse_start();
        for (int i = 0; i < 300; i++) begin
            send_word(temper(gen_state[i]), int'($urandom_range(0, 2)), ok);
        end
        repeat (8) @(posedge clk);
        #1;
        chk("pre_reset_count", 32'(count), 32'd300);
        send_word(temper(gen_state[300]), 0, ok);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_in_ready", 32'(in_ready), 32'd1);
        chk("async_count", 32'(count), 32'd0);
        chk("async_state_ready", 32'(state_ready), 32'd0);
        chk("async_rd_data", rd_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_end_to_end();
        for (int i = 0; i < N - 1; i++) begin
            send_word(temper(gen_state[i]), ($urandom_range(0, 3) == 0) ? 1 : 0, ok);
        end
        repeat (8) @(posedge clk);
        #1;
        chk("e2e_count_623", 32'(count), 32'd623);
        chk("e2e_not_ready_early", 32'(state_ready), 32'd0);
        send_word(temper(gen_state[N-1]), 0, ok);
        repeat (7) @(posedge clk);
        #1;
        chk("e2e_ready_before_write", 32'(state_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("e2e_state_ready", 32'(state_ready), 32'd1);
        chk("e2e_count", 32'(count), 32'd624);
        chk("e2e_in_ready_low", 32'(in_ready), 32'd0);
        for (int a = 0; a < N; a++) begin
            rd(a, d);
            chk("e2e_ram", d, gen_state[a]);
        end
    endtask

    task automatic test_saturation();
        int a;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = $urandom;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            chk("sat_in_ready", 32'(in_ready), 32'd0);
            chk("sat_count", 32'(count), 32'd624);
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            a = (i == 0) ? 0 : int'($urandom_range(0, N - 1));
            rd(a, d);
            chk("sat_ram", d, gen_state[a]);
        end
    endtask

`ifdef MT_UNTEMPER_CHECK_EN
    task automatic test_err();
        logic [31:0] tmp;
        pulse_start();
        chk("err_clear", 32'(err), 32'd0);
        send_word(temper($urandom), 0, ok);
        repeat (7) @(posedge clk);
        #1;
        tmp = dut.r_y;
        force dut.r_y = tmp ^ 32'h1;
        @(posedge clk);
        #1;
        release dut.r_y;
        chk("err_set", 32'(err), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("err_sticky", 32'(err), 32'd1);
        pulse_start();
        chk("err_cleared_by_start", 32'(err), 32'd0);
    endtask
`endif

    initial begin
        build_generator();
        test_reset();
        test_single_word();
        test_random_words();
        test_abort();
        test_async_reset();
        test_end_to_end();
        test_saturation();
`ifdef MT_UNTEMPER_CHECK_EN
        test_err();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mt_untemper
`default_nettype wire
